// File: rtl/mig_pkg.sv
// Shared types and helpers for the MIG truth-table checker.
// The configuration constants here are the widths the operand struct is built on.
package mig_pkg;
  localparam int MIG_NUM_VARS  = 4;
  localparam int MIG_MAX_GATES = 8;
  localparam int MIG_TT_W      = 1 << MIG_NUM_VARS;
  localparam int MIG_IDX_W     = $clog2(MIG_NUM_VARS + MIG_MAX_GATES + 1);
  localparam int MIG_GATE_W    = 3 * (MIG_IDX_W + 1);

  typedef enum logic [1:0] {ST_LOAD, ST_EVAL, ST_DONE} state_e;

  typedef struct packed {
    logic                 inv;
    logic [MIG_IDX_W-1:0] idx;
  } operand_t;

  // Truth table of primary input x(i): bit j = (j >> i) & 1.
  function automatic logic [MIG_TT_W-1:0] proj_tt(input int unsigned i);
    logic [MIG_TT_W-1:0] t;
    t = '0;
    for (int unsigned j = 0; j < MIG_TT_W; j++) t[j] = ((j >> i) & 1) == 1;
    return t;
  endfunction
endpackage

// File: rtl/mig_operand_sel.sv
// Decodes one complemented operand field into a truth table, flagging
// forward/self references and out-of-range indices as errors (value 0).
module mig_operand_sel
  import mig_pkg::*;
#(
  parameter int NUM_VARS  = MIG_NUM_VARS,
  parameter int MAX_GATES = MIG_MAX_GATES,
  parameter int TT_W      = MIG_TT_W,
  parameter int GP_W      = $clog2(MAX_GATES)
) (
  input  operand_t                          opnd_i,
  input  logic [GP_W-1:0]                   cur_i,
  input  logic [MAX_GATES-1:0][TT_W-1:0]    vals_i,
  output logic [TT_W-1:0]                   val_o,
  output logic                              err_o
);
  logic [TT_W-1:0] raw;
  int              idx;
  int              k;

  always_comb begin
    raw   = '0;
    err_o = 1'b0;
    idx   = int'(opnd_i.idx);
    k     = idx - NUM_VARS - 1;
    if (idx == 0) begin
      raw = '0;
    end else if (idx <= NUM_VARS) begin
      raw = proj_tt(idx - 1);
    end else if (idx <= NUM_VARS + MAX_GATES) begin
      if (k >= int'(cur_i)) err_o = 1'b1;
      else                  raw   = vals_i[k[GP_W-1:0]];
    end else begin
      err_o = 1'b1;
    end
    val_o = raw ^ {TT_W{opnd_i.inv}};
  end
endmodule

// File: rtl/mig_tt_checker.sv
// Streams a MIG program in, evaluates one majority gate per cycle on full
// truth tables, then presents the output table and a target-match flag.
module mig_tt_checker
  import mig_pkg::*;
#(
  parameter int NUM_VARS  = MIG_NUM_VARS,
  parameter int MAX_GATES = MIG_MAX_GATES,
  localparam int TT_W     = 1 << NUM_VARS,
  localparam int IDX_W    = $clog2(NUM_VARS + MAX_GATES + 1),
  localparam int GATE_W   = 3 * (IDX_W + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [GATE_W-1:0] cfg_gate,
  input  logic              cfg_last,
  input  logic [TT_W-1:0]   target_tt,
  input  logic              out_inv,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [TT_W-1:0]   res_tt,
  output logic              res_match,
  output logic              res_err
);
  localparam int GP_W  = $clog2(MAX_GATES);
  localparam int CNT_W = GP_W + 1;

  state_e                         state_q, state_d;
  logic [GP_W-1:0]                wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]               rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]               gcnt_q, gcnt_d;
  logic                           err_q, err_d;
  logic [TT_W-1:0]                tgt_q, tgt_d;
  logic                           inv_q, inv_d;
  logic [TT_W-1:0]                res_tt_q, res_tt_d;
  logic                           res_match_q, res_match_d;
  logic                           res_err_q, res_err_d;

  logic [MAX_GATES-1:0][GATE_W-1:0] prog_q;
  logic [MAX_GATES-1:0][TT_W-1:0]   val_q;
  logic                             prog_we, val_we;

  logic [GP_W-1:0]            cur;
  logic [GATE_W-1:0]          gate;
  logic [2:0][TT_W-1:0]       op_val;
  logic [2:0]                 op_err;
  logic [TT_W-1:0]            maj;
  logic [CNT_W-1:0]           glast;
  logic [TT_W-1:0]            fin_tt;

  assign cur   = rd_ptr_q[GP_W-1:0];
  assign gate  = prog_q[cur];
  assign glast = gcnt_q - 1'b1;

  for (genvar p = 0; p < 3; p++) begin : g_op
    mig_operand_sel #(
      .NUM_VARS (NUM_VARS),
      .MAX_GATES(MAX_GATES),
      .TT_W     (TT_W),
      .GP_W     (GP_W)
    ) u_sel (
      .opnd_i(operand_t'(gate[p*(IDX_W+1) +: IDX_W+1])),
      .cur_i (cur),
      .vals_i(val_q),
      .val_o (op_val[p]),
      .err_o (op_err[p])
    );
  end

  assign maj    = (op_val[0] & op_val[1]) | (op_val[0] & op_val[2]) | (op_val[1] & op_val[2]);
  assign fin_tt = val_q[glast[GP_W-1:0]] ^ {TT_W{inv_q}};

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    gcnt_d      = gcnt_q;
    err_d       = err_q;
    tgt_d       = tgt_q;
    inv_d       = inv_q;
    res_tt_d    = res_tt_q;
    res_match_d = res_match_q;
    res_err_d   = res_err_q;
    cfg_ready   = 1'b0;
    res_valid   = 1'b0;
    prog_we     = 1'b0;
    val_we      = 1'b0;
    unique case (state_q)
      ST_LOAD: begin
        cfg_ready = 1'b1;
        if (cfg_valid) begin
          prog_we = 1'b1;
          // A full table without cfg_last is closed off and flagged.
          if (cfg_last || wr_ptr_q == GP_W'(MAX_GATES - 1)) begin
            gcnt_d   = {1'b0, wr_ptr_q} + 1'b1;
            tgt_d    = target_tt;
            inv_d    = out_inv;
            rd_ptr_d = '0;
            state_d  = ST_EVAL;
            if (!cfg_last) err_d = 1'b1;
          end else begin
            wr_ptr_d = wr_ptr_q + 1'b1;
          end
        end
      end
      ST_EVAL: begin
        // rd_ptr == G is the result-register cycle after the last gate.
        if (rd_ptr_q == gcnt_q) begin
          res_tt_d    = fin_tt;
          res_match_d = (fin_tt == tgt_q);
          res_err_d   = err_q;
          state_d     = ST_DONE;
        end else begin
          val_we   = 1'b1;
          err_d    = err_q | (|op_err);
          rd_ptr_d = rd_ptr_q + 1'b1;
        end
      end
      ST_DONE: begin
        res_valid = 1'b1;
        if (res_ready) begin
          state_d  = ST_LOAD;
          wr_ptr_d = '0;
          err_d    = 1'b0;
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_LOAD;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      gcnt_q      <= '0;
      err_q       <= 1'b0;
      tgt_q       <= '0;
      inv_q       <= 1'b0;
      res_tt_q    <= '0;
      res_match_q <= 1'b0;
      res_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      gcnt_q      <= gcnt_d;
      err_q       <= err_d;
      tgt_q       <= tgt_d;
      inv_q       <= inv_d;
      res_tt_q    <= res_tt_d;
      res_match_q <= res_match_d;
      res_err_q   <= res_err_d;
    end
  end

  // Tables are never cleared; only entries 0..G-1 of the current program are read.
  always_ff @(posedge clk) begin
    if (prog_we) prog_q[wr_ptr_q] <= cfg_gate;
    if (val_we)  val_q[cur]       <= maj;
  end

  assign res_tt    = res_tt_q;
  assign res_match = res_match_q;
  assign res_err   = res_err_q;
endmodule

// File: tb/tb_mig_tt_checker.sv
// Directed vector bench for mig_tt_checker with hand-computed truth tables.
module tb_mig_tt_checker;
  localparam int GW = 15;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic [GW-1:0] cfg_gate = '0;
  logic          cfg_last = 1'b0;
  logic [15:0]   target_tt = '0;
  logic          out_inv = 1'b0;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic [15:0]   res_tt;
  logic          res_match;
  logic          res_err;

  int nchk = 0;
  int nerr = 0;

  mig_tt_checker dut (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_gate(cfg_gate), .cfg_last(cfg_last), .target_tt(target_tt),
    .out_inv(out_inv), .res_valid(res_valid), .res_ready(res_ready),
    .res_tt(res_tt), .res_match(res_match), .res_err(res_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string              name;
    int                 n;
    bit                 last;
    logic [7:0][GW-1:0] g;
    logic [15:0]        tgt;
    bit                 inv;
    logic [15:0]        exp_tt;
    bit                 exp_m;
    bit                 exp_e;
    int                 lat;
  } vec_t;

  function automatic logic [4:0] f(input bit inv, input int idx);
    return {inv, 4'(idx)};
  endfunction

  function automatic logic [GW-1:0] gt(input logic [4:0] a, input logic [4:0] b, input logic [4:0] c);
    return {c, b, a};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic send(input vec_t v);
    for (int i = 0; i < v.n; i++) begin
      cfg_valid = 1'b1;
      cfg_gate  = v.g[i];
      cfg_last  = v.last && (i == v.n - 1);
      target_tt = v.tgt;
      out_inv   = v.inv;
      chk({v.name, "/ready_load"}, 32'(cfg_ready), 32'd1);
      @(posedge clk); #1;
    end
    cfg_valid = 1'b0;
    cfg_last  = 1'b0;
  endtask

  task automatic wait_res(input vec_t v);
    int k;
    k = 0;
    chk({v.name, "/ready_eval"}, 32'(cfg_ready), 32'd0);
    while (!res_valid && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    chk({v.name, "/latency"}, 32'(k), 32'(v.lat));
    chk({v.name, "/tt"}, 32'(res_tt), 32'(v.exp_tt));
    chk({v.name, "/match"}, 32'(res_match), 32'(v.exp_m));
    chk({v.name, "/err"}, 32'(res_err), 32'(v.exp_e));
  endtask

  task automatic release_res(input vec_t v);
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    chk({v.name, "/rel_valid"}, 32'(res_valid), 32'd0);
    chk({v.name, "/rel_ready"}, 32'(cfg_ready), 32'd1);
    chk({v.name, "/rel_hold"}, 32'(res_tt), 32'(v.exp_tt));
  endtask

  vec_t vecs[10];
  vec_t vand, vnor, vxor;

  initial begin
    // x0=AAAA x1=CCCC x2=F0F0 x3=FF00; idx 5.. = gates
    vand = '{"and", 1, 1, '0, 16'h8888, 0, 16'h8888, 1, 0, 2};
    vand.g[0] = gt(f(0,1), f(0,2), f(0,0));
    vnor = '{"nor", 1, 1, '0, 16'h1111, 1, 16'h1111, 1, 0, 2};
    vnor.g[0] = gt(f(0,1), f(0,2), f(1,0));
    vxor = '{"xor", 3, 1, '0, 16'h6666, 0, 16'h6666, 1, 0, 4};
    vxor.g[0] = gt(f(0,1), f(0,2), f(0,0));
    vxor.g[1] = gt(f(0,1), f(0,2), f(1,0));
    vxor.g[2] = gt(f(1,5), f(0,6), f(0,0));
    vecs[0] = vand;
    vecs[1] = vnor;
    vecs[2] = vxor;
    vecs[3] = '{"selfref", 1, 1, '0, 16'h8888, 0, 16'h8888, 1, 1, 2};
    vecs[3].g[0] = gt(f(0,5), f(0,1), f(0,2));
    vecs[4] = vand;
    vecs[4].name = "and_after_err";
    vecs[5] = vand;
    vecs[5].name = "nomatch";
    vecs[5].tgt = 16'h1234;
    vecs[5].exp_m = 0;
    vecs[6] = '{"badidx_inv", 1, 1, '0, 16'hEEEE, 0, 16'hEEEE, 1, 1, 2};
    vecs[6].g[0] = gt(f(1,13), f(0,1), f(0,2));
    vecs[7] = '{"fwdref", 2, 1, '0, 16'h8888, 0, 16'h8888, 1, 1, 3};
    vecs[7].g[0] = gt(f(0,1), f(0,2), f(1,0));
    vecs[7].g[1] = gt(f(0,7), f(0,1), f(0,2));
    vecs[8] = '{"overflow", 8, 0, '0, 16'hE8E8, 0, 16'hE8E8, 1, 1, 9};
    for (int i = 0; i < 8; i++) vecs[8].g[i] = gt(f(0,1), f(0,2), f(0,3));
    vecs[9] = '{"x3_cancel", 1, 1, '0, 16'h5555, 1, 16'h5555, 1, 0, 2};
    vecs[9].g[0] = gt(f(0,4), f(1,4), f(0,1));

    #12;
    chk("reset/ready", 32'(cfg_ready), 32'd1);
    chk("reset/valid", 32'(res_valid), 32'd0);
    chk("reset/tt", 32'(res_tt), 32'd0);
    chk("reset/match_err", {30'd0, res_match, res_err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) begin
      send(vecs[i]);
      wait_res(vecs[i]);
      release_res(vecs[i]);
    end

    // Stall: result must hold while res_ready stays low.
    send(vxor);
    wait_res(vxor);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      chk("stall/hold", {13'd0, res_valid, res_match, res_err, res_tt}, {13'd0, 1'b1, 1'b1, 1'b0, 16'h6666});
    end

    // Result handshake and a new beat in the same DONE cycle: beat is not taken.
    res_ready = 1'b1;
    cfg_valid = 1'b1;
    cfg_gate  = vnor.g[0];
    cfg_last  = 1'b1;
    target_tt = vnor.tgt;
    out_inv   = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    chk("simul/valid", 32'(res_valid), 32'd0);
    chk("simul/ready", 32'(cfg_ready), 32'd1);
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    cfg_last  = 1'b0;
    wait_res(vnor);
    release_res(vnor);

    // Reset in the middle of EVAL discards the program.
    send(vxor);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("rst_eval/valid", 32'(res_valid), 32'd0);
    chk("rst_eval/ready", 32'(cfg_ready), 32'd1);
    chk("rst_eval/tt", 32'(res_tt), 32'd0);
    chk("rst_eval/match_err", {30'd0, res_match, res_err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) @(posedge clk);
    #1;
    chk("rst_eval/idle", {30'd0, cfg_ready, res_valid}, 32'd2);
    send(vand);
    wait_res(vand);
    release_res(vand);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
